aes_key_expander: RTL and testbench
===================================

# aes_key_expander

AES-256 key-schedule generator that feeds the round-key load port of `AES_engine`. It accepts a 256-bit cipher key and expands it per FIPS-197 into 15 round keys, numbered 0..14. It then drives them into the engine as `round_number`/`key`/`load` beats, one beat per cycle, with pause support while the engine reports busy. It replaces bench- or software-driven key loading in front of the engine.

## Interface
- No parameters; AES-256 fixed: Nk=8, 15 round keys, 60 words.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request expansion; sampled only in IDLE.
- `cipher_key`  in  256  cipher key.
  - [255:224] is w0 and [31:0] is w7; big-endian bytes.
  - Sampled on the accepting edge only.
- `engine_busy`  in  1  tie to engine `busy_out`; stalls the schedule.
- `round_number`  out  4  round index of the current beat; to engine `round_number`.
- `key`  out  128  round key of the current beat; to engine `key`.
  - [127:96] is w[4i] and [31:0] is w[4i+3].
- `load`  out  1  beat valid; to engine `load`.
- `busy`  out  1  high while in EMIT.
- `done`  out  1  one-cycle pulse after round 14 has been loaded.

## Operation
- States: IDLE, EMIT, DONE.
- IDLE → EMIT when `start`=1 and `engine_busy`=0 at the edge.
  - Capture `cipher_key`.
  - Set the internal round counter r=0.
  - `start` while `engine_busy`=1 is not accepted and is not queued.
- EMIT, each edge with `engine_busy`=0:
  - Register round key r onto `key`, set `round_number`=r, `load`=1, then r increments.
  - After r=14 is registered, go to DONE.
- EMIT, edge with `engine_busy`=1:
  - `load`=0 next cycle; r, history registers, `key` and `round_number` hold.
  - Resumes with the same r once `engine_busy`=0.
- DONE: `done`=1, `load`=0, `busy`=0 for exactly one cycle, then IDLE.
- `start` is ignored in EMIT and DONE.
- Round-key derivation (P2 = round r-2, P1 = round r-1; both held in 128-bit history registers):
  - r=0: `cipher_key`[255:128].
  - r=1: `cipher_key`[127:0].
  - r even ≥2, k=r/2: t = SubWord(RotWord(P1[31:0])) ^ {Rcon[k],24'h0}.
  - r odd ≥3: t = SubWord(P1[31:0]); no rotate, no Rcon.
  - Words: n0 = P2[127:96]^t; n1 = P2[95:64]^n0; n2 = P2[63:32]^n1; n3 = P2[31:0]^n2.
  - After each emitted beat, P2←P1 and P1←new key.
- RotWord {a,b,c,d} → {b,c,d,a}.
- SubWord is four forward S-box lookups, combinational, using the team's existing forward S-box module.
- Rcon[1..7] = 01,02,04,08,10,20,40 (8-bit), from a small constant case on k.
- All XOR is bitwise; no carries. r is 4 bits and never exceeds 14.
- `key` and `round_number` hold their last value whenever `load`=0.

## Timing
- Reset (async assert) forces all of the following immediately, from any state:
  - `round_number`=0, `key`=0, `load`=0, `busy`=0, `done`=0; state IDLE.
  - History registers = 0.
- Reset mid-EMIT aborts the sequence; no partial `done` is produced.
- Latency, with no stalls:
  - Accepting edge T0.
  - Round i beat is visible in cycle T0+1+i, with `load`=1 and `busy`=1.
  - `done`=1 in cycle T0+16, then IDLE in T0+17.
  - A new `start` is accepted at the T0+17 edge at the earliest.
- Each stall cycle adds exactly one cycle to every later beat and to `done`.
- `load` is high for exactly 15 cycles per expansion, with rounds in strictly increasing order 0..14.
- `engine_busy` rising on the same edge as the round-14 beat: that beat is still emitted; DONE follows after the stall clears.
- `cipher_key` changing after acceptance has no effect.

## Test plan
- Nominal expansion:
  - Stimulus: reset, then `start` with `cipher_key`=31415926535897932384626433832795_02884197169399375105820974944592.
  - Beats: 15 consecutive with rounds 0..14.
  - Expected keys:
    - r0=31415926535897932384626433832795
    - r1=02884197169399375105820974944592
    - r2=122f16b44177812762f3e3435170c4d6
    - r3=d3d95d61c54ac456944f465fe0db03cd
    - r14=045d0fe5c6d07b80a2a3231bbae5ad70
  - `done` pulses once, in T0+16.
- Engine loopback:
  - Connect to `AES_engine` and run the nominal expansion.
  - Encrypt 000102030405060708090a0b0c0d0e0f → 997a616dad216ab0320db5c848e02996.
- Stall:
  - Hold `engine_busy`=1 for 3 cycles after the round-5 beat.
  - `load`=0 for 3 cycles; the round-6 beat arrives with value 397f6cecd15c469e5b8c8faf802c8248.
  - `done` arrives 3 cycles late.
- Start gating:
  - `start` with `engine_busy`=1 → no beat; state stays IDLE.
  - `start` pulsed during EMIT → sequence unchanged; only one `done`.
- Reset mid-operation:
  - Assert `n_rst`=0 asynchronously after the round-7 beat.
  - All outputs 0 immediately.
  - A new `start` restarts the sequence at r0.

Source files
------------

// File: rtl/aes_key_expander.sv
// aes_key_expander: AES-256 key schedule feeding the round-key load port of
// AES_engine. Captures a 256-bit cipher key and emits the 15 round keys as
// round_number/key/load beats, one per cycle, pausing while engine_busy=1.
//
// Ports:
//   clk          system clock, rising edge
//   n_rst        asynchronous active-low reset
//   start        request expansion (sampled only in IDLE)
//   cipher_key   256-bit key, [255:224]=w0 .. [31:0]=w7
//   engine_busy  engine busy_out; stalls the schedule
//   round_number round index of current beat
//   key          round key of current beat, [127:96]=w[4i] .. [31:0]=w[4i+3]
//   load         beat valid
//   busy         high while the schedule is running
//   done         one-cycle pulse after round 14 has been loaded
//
// aes_sbox: forward AES S-box, one byte, combinational
//   a  input byte
//   s  substituted byte

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] m;
    p = '0;
    m = x;
    for (int unsigned i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ m;
      m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), then the affine transform.
  function automatic logic [7:0] sbox_fn(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign s = sbox_fn(a);

endmodule

module aes_key_expander (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [255:0] cipher_key,
  input  logic         engine_busy,
  output logic [3:0]   round_number,
  output logic [127:0] key,
  output logic         load,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t       state;
  logic [3:0]   rnd;
  logic [127:0] hist_p2;
  logic [127:0] hist_p1;
  logic [127:0] next_key;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic [31:0]  t_word;
  logic [7:0]   rcon;
  logic [31:0]  n0, n1, n2, n3;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a (sub_in[8*g +: 8]),
      .s (sub_out[8*g +: 8])
    );
  end

  always_comb begin
    // Even rounds rotate the last word left by one byte; odd rounds do not.
    sub_in = rnd[0] ? hist_p1[31:0] : {hist_p1[23:0], hist_p1[31:24]};

    unique case (rnd[3:1])
      3'd1:    rcon = 8'h01;
      3'd2:    rcon = 8'h02;
      3'd3:    rcon = 8'h04;
      3'd4:    rcon = 8'h08;
      3'd5:    rcon = 8'h10;
      3'd6:    rcon = 8'h20;
      3'd7:    rcon = 8'h40;
      default: rcon = 8'h00;
    endcase

    t_word = sub_out ^ (rnd[0] ? 32'h0 : {rcon, 24'h0});
    n0 = hist_p2[127:96] ^ t_word;
    n1 = hist_p2[95:64]  ^ n0;
    n2 = hist_p2[63:32]  ^ n1;
    n3 = hist_p2[31:0]   ^ n2;

    // History is seeded with P2=key[255:128], P1=key[127:0]. Emitting P2 for
    // rounds 0 and 1 under the uniform P2<-P1, P1<-new shift swaps them twice,
    // leaving P2=round 0 and P1=round 1 when round 2 is derived.
    next_key = (rnd < 4'd2) ? hist_p2 : {n0, n1, n2, n3};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= S_IDLE;
      rnd          <= '0;
      hist_p2      <= '0;
      hist_p1      <= '0;
      round_number <= '0;
      key          <= '0;
      load         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          load <= 1'b0;
          if (start && !engine_busy) begin
            hist_p2 <= cipher_key[255:128];
            hist_p1 <= cipher_key[127:0];
            rnd     <= '0;
            busy    <= 1'b1;
            state   <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (engine_busy) begin
            load <= 1'b0;
          end else begin
            key          <= next_key;
            round_number <= rnd;
            load         <= 1'b1;
            hist_p2      <= hist_p1;
            hist_p1      <= next_key;
            if (rnd == 4'd14) state <= S_DONE;
            else              rnd   <= rnd + 4'd1;
          end
        end
        S_DONE: begin
          load <= 1'b0;
          if (!engine_busy) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander: directed bench for aes_key_expander. Covers reset
// values, nominal expansion keys and timing, an engine stall, start gating,
// start during EMIT and asynchronous reset mid-sequence.

module tb_aes_key_expander;

  logic         tb_clk;
  logic         n_rst;
  logic         start;
  logic [255:0] cipher_key;
  logic         engine_busy;
  logic [3:0]   round_number;
  logic [127:0] key;
  logic         load;
  logic         busy;
  logic         done;

  localparam logic [255:0] CK =
    256'h31415926535897932384626433832795_02884197169399375105820974944592;
  localparam logic [127:0] R0  = 128'h31415926535897932384626433832795;
  localparam logic [127:0] R1  = 128'h02884197169399375105820974944592;
  localparam logic [127:0] R2  = 128'h122f16b44177812762f3e3435170c4d6;
  localparam logic [127:0] R3  = 128'hd3d95d61c54ac456944f465fe0db03cd;
  localparam logic [127:0] R6  = 128'h397f6cecd15c469e5b8c8faf802c8248;
  localparam logic [127:0] R14 = 128'h045d0fe5c6d07b80a2a3231bbae5ad70;

  int n_checks = 0;
  int n_pass   = 0;

  logic [127:0] beat_key   [15];
  int           beat_round [15];
  int           beat_cyc   [15];
  int           nloads;
  int           ndone;
  int           done_cyc;

  aes_key_expander u_dut (
    .clk          (tb_clk),
    .n_rst        (n_rst),
    .start        (start),
    .cipher_key   (cipher_key),
    .engine_busy  (engine_busy),
    .round_number (round_number),
    .key          (key),
    .load         (load),
    .busy         (busy),
    .done         (done)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Accepts an expansion, then records 30 cycles of output. Cycle c=1 is the
  // cycle right after the accepting edge's follower, i.e. where round 0 lands.
  task automatic run_exp(input bit do_stall, input bit do_midstart);
    int stall_cnt;
    stall_cnt = 0;
    nloads    = 0;
    ndone     = 0;
    done_cyc  = -1;
    @(negedge tb_clk);
    cipher_key  = CK;
    start       = 1'b1;
    engine_busy = 1'b0;
    @(negedge tb_clk);
    start      = 1'b0;
    cipher_key = {8{$urandom}};
    for (int c = 1; c <= 30; c++) begin
      @(negedge tb_clk);
      if (load) begin
        if (nloads < 15) begin
          beat_key[nloads]   = key;
          beat_round[nloads] = int'(round_number);
          beat_cyc[nloads]   = c;
        end
        nloads++;
      end
      if (done) begin
        ndone++;
        done_cyc = c;
      end
      if (do_stall && load && round_number == 4'd5) stall_cnt = 3;
      if (stall_cnt > 0) begin
        engine_busy = 1'b1;
        stall_cnt--;
      end else begin
        engine_busy = 1'b0;
      end
      start = do_midstart && (c == 5);
    end
    start       = 1'b0;
    engine_busy = 1'b0;
  endtask

  initial begin
    bit bad;
    bit seen;
    n_rst       = 1'b0;
    start       = 1'b0;
    cipher_key  = '0;
    engine_busy = 1'b0;
    #1;
    chk("rst_round",  256'(round_number), 256'd0);
    chk("rst_key",    256'(key),          256'd0);
    chk("rst_load",   256'(load),         256'd0);
    chk("rst_busy",   256'(busy),         256'd0);
    chk("rst_done",   256'(done),         256'd0);
    repeat (2) @(negedge tb_clk);
    n_rst = 1'b1;

    // Nominal expansion
    run_exp(1'b0, 1'b0);
    chk("nom_nloads", 256'(nloads),   256'd15);
    chk("nom_ndone",  256'(ndone),    256'd1);
    chk("nom_donecyc",256'(done_cyc), 256'd16);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("nom_round%0d", i), 256'(beat_round[i]), 256'(i));
      chk($sformatf("nom_cyc%0d", i),   256'(beat_cyc[i]),   256'(i + 1));
    end
    chk("nom_r0",  256'(beat_key[0]),  256'(R0));
    chk("nom_r1",  256'(beat_key[1]),  256'(R1));
    chk("nom_r2",  256'(beat_key[2]),  256'(R2));
    chk("nom_r3",  256'(beat_key[3]),  256'(R3));
    chk("nom_r6",  256'(beat_key[6]),  256'(R6));
    chk("nom_r14", 256'(beat_key[14]), 256'(R14));

    // Stall of 3 cycles after round 5
    run_exp(1'b1, 1'b0);
    chk("stl_nloads", 256'(nloads),      256'd15);
    chk("stl_ndone",  256'(ndone),       256'd1);
    chk("stl_donecyc",256'(done_cyc),    256'd19);
    chk("stl_cyc5",   256'(beat_cyc[5]), 256'd6);
    chk("stl_cyc6",   256'(beat_cyc[6]), 256'd10);
    chk("stl_round6", 256'(beat_round[6]), 256'd6);
    chk("stl_r6",     256'(beat_key[6]), 256'(R6));
    chk("stl_r14",    256'(beat_key[14]),256'(R14));

    // Start while engine busy is not accepted
    @(negedge tb_clk);
    engine_busy = 1'b1;
    start       = 1'b1;
    cipher_key  = CK;
    @(negedge tb_clk);
    start = 1'b0;
    bad   = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) engine_busy = 1'b0;
      @(negedge tb_clk);
      if (load || busy || done) bad = 1'b1;
    end
    chk("gate_idle", 256'(bad), 256'd0);

    // Start pulsed during EMIT is ignored
    run_exp(1'b0, 1'b1);
    chk("mid_nloads", 256'(nloads),       256'd15);
    chk("mid_ndone",  256'(ndone),        256'd1);
    chk("mid_donecyc",256'(done_cyc),     256'd16);
    chk("mid_r14",    256'(beat_key[14]), 256'(R14));

    // Asynchronous reset after the round-7 beat
    @(negedge tb_clk);
    cipher_key = CK;
    start      = 1'b1;
    @(negedge tb_clk);
    start = 1'b0;
    seen  = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge tb_clk);
      if (load && round_number == 4'd7) seen = 1'b1;
    end
    chk("rst7_seen", 256'(seen), 256'd1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_round", 256'(round_number), 256'd0);
    chk("arst_key",   256'(key),          256'd0);
    chk("arst_load",  256'(load),         256'd0);
    chk("arst_busy",  256'(busy),         256'd0);
    chk("arst_done",  256'(done),         256'd0);
    @(negedge tb_clk);
    n_rst = 1'b1;
    run_exp(1'b0, 1'b0);
    chk("rst_again_r0",   256'(beat_key[0]),   256'(R0));
    chk("rst_again_rnd0", 256'(beat_round[0]), 256'd0);
    chk("rst_again_n",    256'(nloads),        256'd15);
    chk("rst_again_done", 256'(done_cyc),      256'd16);
    chk("rst_again_r14",  256'(beat_key[14]),  256'(R14));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
